pc_sequencer: RTL and testbench

Parametrised next-generation program counter for the core fetch stage. Holds the current PC and selects the next PC each cycle from these sources: hold, sequential advance, branch/jump redirect, trap entry, and return-from-trap. A misaligned control-transfer target is detected before it is loaded. The block then enters a FAULT state that freezes the PC until the trap logic acknowledges. It captures the exception PC (EPC) and the faulting address for the CSR and trap unit.

---
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Request/status bundle between the fetch-stage control logic (master) and the
// program counter sequencer (slave).
interface pc_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            advance;
  logic            inc_half;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            trap;
  logic            mret;
  logic            trap_ack;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] epc;
  logic            fault;
  logic [XLEN-1:0] fault_addr;
  logic            busy_fault;

  modport master (
    output advance, inc_half, redirect, redirect_target, trap, mret, trap_ack,
    input  pc, epc, fault, fault_addr, busy_fault
  );

  modport slave (
    input  advance, inc_half, redirect, redirect_target, trap, mret, trap_ack,
    output pc, epc, fault, fault_addr, busy_fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with trap entry/return and misaligned-target fault capture.
// Define C_EXT_EN for 2-byte alignment and half-word (+2) sequential advance.
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h10)
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic {
    RUN,
    FAULT
  } state_e;

`ifdef C_EXT_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(1);
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);
`endif

  // Misaligned vectors would fault forever, so reject them when the design is built.
  generate
    if ((RESET_VECTOR & ALIGN_MASK) != '0) begin : gBadResetVector
      $error("pc_sequencer: RESET_VECTOR is misaligned");
    end
    if ((TRAP_VECTOR & ALIGN_MASK) != '0) begin : gBadTrapVector
      $error("pc_sequencer: TRAP_VECTOR is misaligned");
    end
  endgenerate

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] faultAddr_q, faultAddr_d;
  logic [XLEN-1:0] candidate;
  logic [XLEN-1:0] step;

`ifdef C_EXT_EN
  assign step = bus.inc_half ? XLEN'(2) : XLEN'(4);
`else
  logic unusedIncHalf;
  assign unusedIncHalf = bus.inc_half;
  assign step          = XLEN'(4);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_VECTOR;
      epc_q       <= '0;
      faultAddr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      faultAddr_q <= faultAddr_d;
    end
  end

  // Trap beats every transfer, so a trap masks a misaligned redirect in the same cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    faultAddr_d = faultAddr_q;
    candidate   = bus.mret ? epc_q : bus.redirect_target;

    case (state_q)
      RUN: begin
        if (bus.trap) begin
          epc_d = pc_q;
          pc_d  = TRAP_VECTOR;
        end else if (bus.mret || bus.redirect) begin
          if ((candidate & ALIGN_MASK) != '0) begin
            epc_d       = pc_q;
            faultAddr_d = candidate;
            state_d     = FAULT;
          end else begin
            pc_d = candidate;
          end
        end else if (bus.advance) begin
          pc_d = pc_q + step;
        end
      end
      FAULT: begin
        if (bus.trap_ack) begin
          pc_d    = TRAP_VECTOR;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.pc         = pc_q;
  assign bus.epc        = epc_q;
  assign bus.fault      = (state_q == FAULT);
  assign bus.busy_fault = (state_q == FAULT);
  assign bus.fault_addr = faultAddr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with immediate-assertion checks.
// Also covers the half-word variant when built with C_EXT_EN.
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  pc_sequencer_if #(.XLEN(32)) bus ();

  pc_sequencer #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0),
    .TRAP_VECTOR (32'h10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of requests, let one edge pass, then release everything.
  task automatic applyStimulus(input logic rst, input logic adv, input logic half,
                               input logic red, input logic [31:0] tgt,
                               input logic trp, input logic ret, input logic ack);
    reset               = rst;
    bus.advance         = adv;
    bus.inc_half        = half;
    bus.redirect        = red;
    bus.redirect_target = tgt;
    bus.trap            = trp;
    bus.mret            = ret;
    bus.trap_ack        = ack;
    @(posedge clk);
    #1;
    reset               = 1'b0;
    bus.advance         = 1'b0;
    bus.inc_half        = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
    bus.trap            = 1'b0;
    bus.mret            = 1'b0;
    bus.trap_ack        = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expPc,
                             input logic [31:0] expEpc, input logic expFault,
                             input logic [31:0] expFaultAddr);
    assertCount++;
    assert (bus.pc === expPc) else begin
      failCount++;
      $error("[TB] FAIL %s pc: observed %h expected %h", tag, bus.pc, expPc);
    end
    assertCount++;
    assert (bus.epc === expEpc) else begin
      failCount++;
      $error("[TB] FAIL %s epc: observed %h expected %h", tag, bus.epc, expEpc);
    end
    assertCount++;
    assert (bus.fault === expFault) else begin
      failCount++;
      $error("[TB] FAIL %s fault: observed %b expected %b", tag, bus.fault, expFault);
    end
    assertCount++;
    assert (bus.busy_fault === expFault) else begin
      failCount++;
      $error("[TB] FAIL %s busy_fault: observed %b expected %b", tag, bus.busy_fault, expFault);
    end
    assertCount++;
    assert (bus.fault_addr === expFaultAddr) else begin
      failCount++;
      $error("[TB] FAIL %s fault_addr: observed %h expected %h", tag, bus.fault_addr, expFaultAddr);
    end
  endtask

  initial begin
    assertCount         = 0;
    failCount           = 0;
    reset               = 1'b1;
    bus.advance         = 1'b0;
    bus.inc_half        = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
    bus.trap            = 1'b0;
    bus.mret            = 1'b0;
    bus.trap_ack        = 1'b0;

    //            rst  adv  half red  target        trap mret ack
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0);
    checkOutput("reset", 32'h0, 32'h0, 1'b0, 32'h0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    checkOutput("adv1", 32'h4, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    checkOutput("adv2", 32'h8, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    checkOutput("adv3", 32'hC, 32'h0, 1'b0, 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    checkOutput("hold", 32'hC, 32'h0, 1'b0, 32'h0);

    // Redirect outranks advance.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h100,      1'b0, 1'b0, 1'b0);
    checkOutput("redirect", 32'h100, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h102,      1'b0, 1'b0, 1'b0);
`ifdef C_EXT_EN
    checkOutput("redirHalf", 32'h102, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h100,      1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h103,      1'b0, 1'b0, 1'b0);
    checkOutput("misalign", 32'h100, 32'h100, 1'b1, 32'h103);
`else
    checkOutput("misalign", 32'h100, 32'h100, 1'b1, 32'h102);
`endif

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h200,      1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0);
`ifdef C_EXT_EN
    checkOutput("faultHold", 32'h100, 32'h100, 1'b1, 32'h103);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
    checkOutput("trapAck", 32'h10, 32'h100, 1'b0, 32'h103);
`else
    checkOutput("faultHold", 32'h100, 32'h100, 1'b1, 32'h102);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
    checkOutput("trapAck", 32'h10, 32'h100, 1'b0, 32'h102);
`endif

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
    assertCount++;
    assert (bus.pc === 32'h10) else begin
      failCount++;
      $error("[TB] FAIL ackInRun pc: observed %h expected %h", bus.pc, 32'h10);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h40,       1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h80,       1'b1, 1'b0, 1'b0);
    assertCount++;
    assert (bus.pc === 32'h10 && bus.epc === 32'h40) else begin
      failCount++;
      $error("[TB] FAIL trapWins pc/epc: observed %h/%h expected %h/%h", bus.pc, bus.epc, 32'h10, 32'h40);
    end
    // mret outranks a simultaneous redirect and leaves epc alone.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h300,      1'b0, 1'b1, 1'b0);
    assertCount++;
    assert (bus.pc === 32'h40 && bus.epc === 32'h40 && bus.fault === 1'b0) else begin
      failCount++;
      $error("[TB] FAIL mret pc/epc/fault: observed %h/%h/%b expected %h/%h/%b",
             bus.pc, bus.epc, bus.fault, 32'h40, 32'h40, 1'b0);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h83,       1'b1, 1'b0, 1'b0);
    assertCount++;
    assert (bus.pc === 32'h10 && bus.epc === 32'h40 && bus.fault === 1'b0) else begin
      failCount++;
      $error("[TB] FAIL trapMasksFault pc/epc/fault: observed %h/%h/%b expected %h/%h/%b",
             bus.pc, bus.epc, bus.fault, 32'h10, 32'h40, 1'b0);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    checkOutput("wrap4", 32'h0, 32'h40, 1'b0, 32'h0000_0000 | bus.fault_addr);

`ifdef C_EXT_EN
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    checkOutput("toTop", 32'hFFFF_FFFE, 32'h40, 1'b0, 32'h103);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    checkOutput("wrap2", 32'h0, 32'h40, 1'b0, 32'h103);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    checkOutput("half", 32'h2, 32'h40, 1'b0, 32'h103);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    checkOutput("full", 32'h6, 32'h40, 1'b0, 32'h103);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h103,      1'b0, 1'b0, 1'b0);
    checkOutput("oddFault", 32'h6, 32'h6, 1'b1, 32'h103);
`else
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    checkOutput("halfIgnored", 32'h4, 32'h40, 1'b0, 32'h102);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h101,      1'b0, 1'b0, 1'b0);
    checkOutput("oddFault", 32'h4, 32'h4, 1'b1, 32'h101);
`endif

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
    checkOutput("resetInFault", 32'h0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
    checkOutput("runAfterReset", 32'h4, 32'h0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
